// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, STAT/CTRL bit positions
// and the TX/RX framing state encodings.
package uart_pkg;

  localparam logic [7:0] RegData = 8'd0;
  localparam logic [7:0] RegStat = 8'd1;
  localparam logic [7:0] RegCtrl = 8'd2;
  localparam logic [7:0] RegDiv  = 8'd3;

  localparam int unsigned StatTxFull  = 0;
  localparam int unsigned StatTxEmpty = 1;
  localparam int unsigned StatRxEmpty = 2;
  localparam int unsigned StatRxFull  = 3;
  localparam int unsigned StatRxOvr   = 4;
  localparam int unsigned StatFrmErr  = 5;
  localparam int unsigned StatTxBusy  = 6;
  localparam int unsigned StatTxOvf   = 7;

  localparam int unsigned CtrlTxEn       = 0;
  localparam int unsigned CtrlRxEn       = 1;
  localparam int unsigned CtrlIrqRx      = 2;
  localparam int unsigned CtrlIrqTxEmpty = 3;
  localparam int unsigned CtrlIrqErr     = 4;
  localparam int unsigned CtrlLoopback   = 5;
  localparam int unsigned CtrlWidth      = 6;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop is only honoured when non-empty; a push
// into a full FIFO is accepted only when a valid pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CountFull) || do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_fifo_periph.sv
// Bus-mapped UART: TX/RX FIFOs, 16x oversampling tick generator, framing FSMs,
// sticky error flags and a registered level interrupt.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DIV_DEFAULT = 16'd27,
  parameter int unsigned DATA_BITS   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  addrIn,
  input  logic [7:0]  addrOut,
  input  logic [3:0]  sizeDecode,
  input  logic [31:0] dataIn,
  input  logic        rdEn,
  output logic [31:0] dataOut,
  output logic        IRQ,
  output logic        TXD,
  input  logic        RXD
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  logic [CtrlWidth-1:0] ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d, tick_cnt_q, tick_cnt_d, div_eff;
  logic        tick;
  tx_state_e   tx_state_q, tx_state_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d, rx_cnt_q, rx_cnt_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_rdata, rx_rdata;
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_in, rx_fall, tx_line, tx_busy;
  logic        tx_push, tx_pop, rx_push, rx_pop, tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic        rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;
  logic        ovr_set, frm_set, w1c_en;
  logic [31:0] dout_q, dout_d, stat;
  logic        unused_bits;

  assign unused_bits = ^{dataIn[31:16], sizeDecode[3:2]};

  // Reload-style divider: a new DIV value is only picked up when the counter reloads.
  always_comb begin
    div_eff    = (div_q == '0) ? 16'd1 : div_q;
    tick       = (tick_cnt_q <= 16'd1);
    tick_cnt_d = tick ? div_eff : tick_cnt_q - 16'd1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (ctrl_q[CtrlTxEn] && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        tx_line = 1'b0;
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) tx_state_d = TxData;
        end
      end
      TxData: begin
        tx_line = tx_shift_q[0];
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 4'd1;
            if (tx_bit_q == LastBit) tx_state_d = TxStop;
          end
        end
      end
      TxStop: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign tx_busy = (tx_state_q != TxIdle);

  // Loopback bypasses the synchroniser: the TX line is already in this clock domain.
  assign rx_in   = ctrl_q[CtrlLoopback] ? tx_line : rx_sync_q[1];
  assign rx_fall = rx_prev_q && !rx_in;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    frm_set    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (ctrl_q[CtrlRxEn] && rx_fall) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7 && rx_in) rx_state_d = RxIdle;
          else if (rx_cnt_q == 4'd15)    rx_state_d = RxData;
        end
      end
      RxData: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7) rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_cnt_q == 4'd15) begin
            rx_bit_d = rx_bit_q + 4'd1;
            if (rx_bit_q == LastBit) rx_state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          // Decide at mid-stop so the next start edge is never missed.
          if (rx_cnt_q == 4'd7) begin
            rx_state_d = RxIdle;
            if (!rx_in)                  frm_set = 1'b1;
            else if (rx_full && !rx_pop) ovr_set = 1'b1;
            else                         rx_push = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    tx_push = sizeDecode[0] && (addrIn == RegData);
    w1c_en  = sizeDecode[0] && (addrIn == RegStat);
    rx_pop  = rdEn && (addrOut == RegData) && !rx_empty;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    if (sizeDecode[0] && addrIn == RegCtrl) ctrl_d = dataIn[CtrlWidth-1:0];
    if (addrIn == RegDiv) begin
      if (sizeDecode[0]) div_d[7:0]  = dataIn[7:0];
      if (sizeDecode[1]) div_d[15:8] = dataIn[15:8];
    end
    // Set beats clear when both land in the same cycle.
    rx_ovr_d  = (rx_ovr_q  && !(w1c_en && dataIn[StatRxOvr]))  || ovr_set;
    frm_err_d = (frm_err_q && !(w1c_en && dataIn[StatFrmErr])) || frm_set;
    tx_ovf_d  = (tx_ovf_q  && !(w1c_en && dataIn[StatTxOvf]))  || (tx_push && tx_full && !tx_pop);
    stat = {8'h00, 8'(tx_count), 8'(rx_count), tx_ovf_q, tx_busy, frm_err_q, rx_ovr_q,
            rx_full, rx_empty, tx_empty, tx_full};
    dout_d = dout_q;
    if (rdEn) begin
      case (addrOut)
        RegData: dout_d = rx_empty ? 32'h0 : 32'(rx_rdata);
        RegStat: dout_d = stat;
        RegCtrl: dout_d = 32'(ctrl_q);
        RegDiv:  dout_d = 32'(div_q);
        default: dout_d = 32'h0;
      endcase
    end
    irq_d = (ctrl_q[CtrlIrqRx] && !rx_empty)
         || (ctrl_q[CtrlIrqTxEmpty] && tx_empty && !tx_busy)
         || (ctrl_q[CtrlIrqErr] && (rx_ovr_q || frm_err_q || tx_ovf_q));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q     <= CtrlWidth'(6'h03);
      div_q      <= DIV_DEFAULT;
      tick_cnt_q <= DIV_DEFAULT;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_ovr_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= {rx_sync_q[0], RXD};
      rx_prev_q  <= rx_in;
      rx_ovr_q   <= rx_ovr_d;
      frm_err_q  <= frm_err_d;
      tx_ovf_q   <= tx_ovf_d;
      irq_q      <= irq_d;
      dout_q     <= dout_d;
    end
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .push_i (tx_push),
    .wdata_i(dataIn[DATA_BITS-1:0]),
    .pop_i  (tx_pop),
    .rdata_o(tx_rdata),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .push_i (rx_push),
    .wdata_i(rx_shift_q),
    .pop_i  (rx_pop),
    .rdata_o(rx_rdata),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(rx_count)
  );

  assign TXD     = ctrl_q[CtrlLoopback] ? 1'b1 : tx_line;
  assign IRQ     = irq_q;
  assign dataOut = dout_q;

endmodule
